// File: rtl/counter_0to5.sv
// Up-counting BCD phase timer: counts 0..LIMIT while Bs or Vs is present,
// honouring pause/Error/clear, and reports completion via done and carry.
module counter_0to5 #(
  parameter int LIMIT = 5,
  parameter bit WRAP  = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Bs,
  input  logic       Vs,
  input  logic       Error,
  input  logic       pause,
  input  logic       tick,
  input  logic       clear,
  output logic [3:0] bcd,
  output logic       carry,
  output logic       done,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    PAUSED,
    DONE,
    FAULT
  } state_t;

  localparam logic [3:0] LIM = 4'(LIMIT);

  state_t state_reg;
  logic   act;

  assign act  = Bs | Vs;
  assign busy = (state_reg == COUNT) || (state_reg == PAUSED);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      bcd       <= 4'd0;
      carry     <= 1'b0;
      done      <= 1'b0;
    end else begin
      carry <= 1'b0;
      if (Error) begin
        state_reg <= FAULT;
        bcd       <= 4'd0;
        done      <= 1'b0;
      end else if (state_reg == FAULT) begin
        // Only an explicit clear with Error deasserted releases the fault.
        bcd <= 4'd0;
        if (clear) begin
          state_reg <= IDLE;
        end
      end else if (clear || !act) begin
        state_reg <= IDLE;
        bcd       <= 4'd0;
        done      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg <= COUNT;
          end
          COUNT: begin
            if (pause) begin
              state_reg <= PAUSED;
            end else if (tick) begin
              if (bcd < LIM) begin
                bcd <= bcd + 4'd1;
                if (!WRAP && (bcd + 4'd1 == LIM)) begin
                  state_reg <= DONE;
                  done      <= 1'b1;
                  carry     <= 1'b1;
                end
              end else begin
                // Only reachable with WRAP=1: roll LIMIT back to zero.
                bcd   <= 4'd0;
                carry <= 1'b1;
              end
            end
          end
          PAUSED: begin
            if (!pause) begin
              state_reg <= COUNT;
            end
          end
          DONE: begin
            done <= 1'b1;
          end
          default: begin
            state_reg <= IDLE;
            bcd       <= 4'd0;
            done      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_0to5.sv
// Self-checking bench for counter_0to5: directed scenarios plus a randomized
// run compared against a flag-based behavioural model of the timer.
module tb_counter_0to5;

  logic clock = 1'b0;
  logic reset, Bs, Vs, Error, pause, tick, clear;
  logic [3:0] bcd_a, bcd_b;
  logic carry_a, done_a, busy_a, carry_b, done_b, busy_b;
  logic [6:0] obs_a, obs_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  // A: LIMIT=5 stop-at-limit; B: LIMIT=3 wrapping.
  counter_0to5 #(.LIMIT(5), .WRAP(1'b0)) dut_a (
    .clock(clock), .reset(reset), .Bs(Bs), .Vs(Vs), .Error(Error),
    .pause(pause), .tick(tick), .clear(clear),
    .bcd(bcd_a), .carry(carry_a), .done(done_a), .busy(busy_a)
  );
  counter_0to5 #(.LIMIT(3), .WRAP(1'b1)) dut_b (
    .clock(clock), .reset(reset), .Bs(Bs), .Vs(Vs), .Error(Error),
    .pause(pause), .tick(tick), .clear(clear),
    .bcd(bcd_b), .carry(carry_b), .done(done_b), .busy(busy_b)
  );

  assign obs_a = {bcd_a, carry_a, done_a, busy_a};
  assign obs_b = {bcd_b, carry_b, done_b, busy_b};

  // Model: elapsed count plus independent flags for running / held / finished / faulted.
  typedef struct packed {
    logic [3:0] cnt;
    logic run;
    logic hold;
    logic fin;
    logic flt;
    logic cy;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t advance(mdl_t m, int limit, bit wrap);
    mdl_t n = m;
    n.cy = 1'b0;
    if (reset) begin
      n = '0;
    end else if (Error) begin
      n = '0;
      n.flt = 1'b1;
    end else if (m.flt) begin
      n.cnt = 0;
      if (clear) n.flt = 1'b0;
    end else if (clear || !(Bs || Vs)) begin
      n = '0;
    end else if (m.fin) begin
      n.fin = 1'b1;
    end else if (!m.run && !m.hold) begin
      n.run = 1'b1;
    end else if (m.hold) begin
      if (!pause) begin
        n.hold = 1'b0;
        n.run  = 1'b1;
      end
    end else if (pause) begin
      n.run  = 1'b0;
      n.hold = 1'b1;
    end else if (tick) begin
      if (int'(m.cnt) == limit) begin
        n.cnt = 0;
        n.cy  = 1'b1;
      end else begin
        n.cnt = m.cnt + 4'd1;
        if (int'(n.cnt) == limit && !wrap) begin
          n.fin = 1'b1;
          n.run = 1'b0;
          n.cy  = 1'b1;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [6:0] expect_of(mdl_t m);
    return {m.cnt, m.cy, m.fin, m.run | m.hold};
  endfunction

  task automatic step();
    @(posedge clock);
    ma = advance(ma, 5, 1'b0);
    mb = advance(mb, 3, 1'b1);
    #1;
  endtask

  task automatic idle_inputs();
    Bs = 0; Vs = 0; Error = 0; pause = 0; tick = 0; clear = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs_a !== 7'b0000_000) begin
      n_fail++; $display("FAIL reset_a obs=%b exp=%b", obs_a, 7'b0000_000);
    end
    n_checks++;
    if (obs_b !== 7'b0000_000) begin
      n_fail++; $display("FAIL reset_b obs=%b exp=%b", obs_b, 7'b0000_000);
    end
    $display("test_reset done");
  endtask

  task automatic test_count_to_limit();
    logic [6:0] exp;
    do_reset();
    Bs = 1; tick = 1;
    step();
    n_checks++;
    if (obs_a !== {4'd0, 3'b001}) begin
      n_fail++; $display("FAIL start_latency obs=%b exp=%b", obs_a, {4'd0, 3'b001});
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      exp = (i == 5) ? {4'd5, 3'b110} : {4'(i), 3'b001};
      n_checks++;
      if (obs_a !== exp) begin
        n_fail++; $display("FAIL count_up i=%0d obs=%b exp=%b", i, obs_a, exp);
      end
    end
    step();
    n_checks++;
    if (obs_a !== {4'd5, 3'b010}) begin
      n_fail++; $display("FAIL done_hold obs=%b exp=%b", obs_a, {4'd5, 3'b010});
    end
    $display("test_count_to_limit done");
  endtask

  task automatic test_pause();
    do_reset();
    Bs = 1; tick = 1;
    step();
    for (int i = 0; i < 3; i++) step();
    pause = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (obs_a !== {4'd3, 3'b001}) begin
        n_fail++; $display("FAIL pause_hold i=%0d obs=%b exp=%b", i, obs_a, {4'd3, 3'b001});
      end
    end
    pause = 0;
    step();
    n_checks++;
    if (obs_a !== {4'd3, 3'b001}) begin
      n_fail++; $display("FAIL pause_resume obs=%b exp=%b", obs_a, {4'd3, 3'b001});
    end
    step();
    n_checks++;
    if (obs_a !== {4'd4, 3'b001}) begin
      n_fail++; $display("FAIL pause_next obs=%b exp=%b", obs_a, {4'd4, 3'b001});
    end
    $display("test_pause done");
  endtask

  task automatic test_drop_act();
    do_reset();
    Bs = 1; tick = 1;
    step();
    step();
    step();
    Bs = 0;
    step();
    n_checks++;
    if (obs_a !== {4'd0, 3'b000}) begin
      n_fail++; $display("FAIL drop_act obs=%b exp=%b", obs_a, {4'd0, 3'b000});
    end
    Vs = 1;
    step();
    n_checks++;
    if (obs_a !== {4'd0, 3'b001}) begin
      n_fail++; $display("FAIL restart_vs obs=%b exp=%b", obs_a, {4'd0, 3'b001});
    end
    step();
    n_checks++;
    if (obs_a !== {4'd1, 3'b001}) begin
      n_fail++; $display("FAIL restart_inc obs=%b exp=%b", obs_a, {4'd1, 3'b001});
    end
    $display("test_drop_act done");
  endtask

  task automatic test_error();
    do_reset();
    Bs = 1; tick = 1;
    step();
    for (int i = 0; i < 4; i++) step();
    Error = 1;
    step();
    n_checks++;
    if (obs_a !== {4'd0, 3'b000}) begin
      n_fail++; $display("FAIL error_entry obs=%b exp=%b", obs_a, {4'd0, 3'b000});
    end
    Error = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (obs_a !== {4'd0, 3'b000}) begin
        n_fail++; $display("FAIL fault_hold i=%0d obs=%b exp=%b", i, obs_a, {4'd0, 3'b000});
      end
    end
    clear = 1;
    step();
    clear = 0;
    step();
    n_checks++;
    if (obs_a !== {4'd0, 3'b001}) begin
      n_fail++; $display("FAIL fault_release obs=%b exp=%b", obs_a, {4'd0, 3'b001});
    end
    step();
    n_checks++;
    if (obs_a !== {4'd1, 3'b001}) begin
      n_fail++; $display("FAIL fault_resume obs=%b exp=%b", obs_a, {4'd1, 3'b001});
    end
    Error = 1; clear = 1;
    step();
    Error = 0; clear = 0;
    step();
    n_checks++;
    if (obs_a !== {4'd0, 3'b000}) begin
      n_fail++; $display("FAIL clear_and_error obs=%b exp=%b", obs_a, {4'd0, 3'b000});
    end
    clear = 1;
    step();
    clear = 0;
    $display("test_error done");
  endtask

  task automatic test_wrap();
    int exp_seq[5] = '{1, 2, 3, 0, 1};
    logic [6:0] exp;
    do_reset();
    Bs = 1; tick = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      exp = {4'(exp_seq[i]), (i == 3), 2'b01};
      n_checks++;
      if (obs_b !== exp) begin
        n_fail++; $display("FAIL wrap i=%0d obs=%b exp=%b", i, obs_b, exp);
      end
    end
    $display("test_wrap done");
  endtask

  task automatic test_gated_tick();
    int exp_cnt = 0;
    do_reset();
    Bs = 1; tick = 0;
    step();
    for (int c = 1; c <= 6; c++) begin
      tick = ((c % 3) == 0);
      step();
      if (tick) exp_cnt++;
      n_checks++;
      if (obs_a !== {4'(exp_cnt), 3'b001}) begin
        n_fail++; $display("FAIL gated_tick c=%0d obs=%b exp=%b", c, obs_a, {4'(exp_cnt), 3'b001});
      end
    end
    reset = 1; tick = 1;
    step();
    reset = 0;
    n_checks++;
    if (obs_a !== {4'd0, 3'b000}) begin
      n_fail++; $display("FAIL reset_midcount obs=%b exp=%b", obs_a, {4'd0, 3'b000});
    end
    $display("test_gated_tick done");
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(99) < 2);
      Error = ($urandom_range(99) < 3);
      clear = ($urandom_range(99) < 4);
      Bs    = ($urandom_range(99) < 75);
      Vs    = ($urandom_range(99) < 30);
      pause = ($urandom_range(99) < 15);
      tick  = ($urandom_range(99) < 65);
      step();
      n_checks++;
      if (obs_a !== expect_of(ma)) begin
        n_fail++; $display("FAIL random_a c=%0d obs=%b exp=%b", c, obs_a, expect_of(ma));
      end
      n_checks++;
      if (obs_b !== expect_of(mb)) begin
        n_fail++; $display("FAIL random_b c=%0d obs=%b exp=%b", c, obs_b, expect_of(mb));
      end
      $display("rnd c=%0d in=%b a=%b b=%b", c,
               {reset, Error, clear, Bs, Vs, pause, tick}, obs_a, obs_b);
    end
  endtask

  initial begin
    ma = '0;
    mb = '0;
    reset = 1;
    idle_inputs();
    test_reset();
    test_count_to_limit();
    test_pause();
    test_drop_act();
    test_error();
    test_wrap();
    test_gated_tick();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
